cell_sync_nffs: RTL and testbench

CELL_SYNC_NFFS -- requirements
Module: cell_sync_nffs

---
 rtl/cell_sync_nffs_pkg.sv | 10 +
 rtl/cell_sync_nffs_bit.sv | 91 +++++++++
 rtl/cell_sync_nffs.sv | 46 ++++
 tb/tb_cell_sync_nffs.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cell_sync_nffs_pkg.sv
// Shared limits for the multi-bit synchronizer cell and its per-channel slice.
package cell_sync_nffs_pkg;

    localparam int unsigned MIN_WIDTH    = 1;
    localparam int unsigned MAX_WIDTH    = 64;
    localparam int unsigned MIN_STAGES   = 2;
    localparam int unsigned MAX_STAGES   = 4;
    localparam int unsigned MAX_FILT_LEN = 255;

endpackage

// File: rtl/cell_sync_nffs_bit.sv
// One synchronizer channel: flop chain, optional glitch filter, and edge history.
module cell_sync_nffs_bit
    import cell_sync_nffs_pkg::*;
#(
    parameter int unsigned STAGES   = 2,
    parameter logic        RST_VAL  = 1'b1,
    parameter int unsigned FILT_LEN = 0
) (
    input  logic CK,
    input  logic RST,
    input  logic D,
    output logic Q,
    output logic RISE,
    output logic FALL
);

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic s;
    logic filt;
    logic qd_q;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], D};
        end
    end

    assign s = sync_q[STAGES-1];

    if (FILT_LEN == 0) begin : g_bypass
        assign filt = s;
    end else begin : g_filter
        localparam int unsigned CNT_W = (clog2(FILT_LEN) < 1) ? 1 : clog2(FILT_LEN);
        localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             filt_q, filt_d;

        // Count only while S disagrees with Q; any agreement restarts the window.
        always_comb begin
            cnt_d  = cnt_q;
            filt_d = filt_q;
            if (s == filt_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                filt_d = s;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge CK or posedge RST) begin
            if (RST) begin
                cnt_q  <= '0;
                filt_q <= RST_VAL;
            end else begin
                cnt_q  <= cnt_d;
                filt_q <= filt_d;
            end
        end

        assign filt = filt_q;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            qd_q <= RST_VAL;
        end else begin
            qd_q <= filt;
        end
    end

    assign Q    = filt;
    assign RISE = filt & ~qd_q;
    assign FALL = ~filt & qd_q;

endmodule

// File: rtl/cell_sync_nffs.sv
// WIDTH independent synchronizer channels with glitch filter and edge pulses.
module cell_sync_nffs
    import cell_sync_nffs_pkg::*;
#(
    parameter int unsigned      WIDTH    = 1,
    parameter int unsigned      STAGES   = 2,
    parameter logic [WIDTH-1:0] RST_VAL  = '1,
    parameter int unsigned      FILT_LEN = 0
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             CHG
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "cell_sync_nffs: WIDTH must be within 1..64");
    end
    if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
        $fatal(1, "cell_sync_nffs: STAGES must be within 2..4");
    end
    if (FILT_LEN > MAX_FILT_LEN) begin : g_bad_filt
        $fatal(1, "cell_sync_nffs: FILT_LEN must be within 0..255");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        cell_sync_nffs_bit #(
            .STAGES  (STAGES),
            .RST_VAL (RST_VAL[i]),
            .FILT_LEN(FILT_LEN)
        ) u_bit (
            .CK  (CK),
            .RST (RST),
            .D   (D[i]),
            .Q   (Q[i]),
            .RISE(RISE[i]),
            .FALL(FALL[i])
        );
    end

    assign CHG = |(RISE | FALL);

endmodule

// File: tb/tb_cell_sync_nffs.sv
// Scoreboarded directed bench across four parameterisations of cell_sync_nffs.
module tb_cell_sync_nffs;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    int unsigned cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    logic       rst0, rst1, rst2, rst3;
    logic       d0, d1, d3;
    logic [7:0] d2;
    logic       q0, rise0, fall0, chg0;
    logic       q1, rise1, fall1, chg1;
    logic [7:0] q2, rise2, fall2;
    logic       chg2;
    logic       q3, rise3, fall3, chg3;

    cell_sync_nffs #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b1), .FILT_LEN(0)) u0 (
        .CK(CK), .RST(rst0), .D(d0), .Q(q0), .RISE(rise0), .FALL(fall0), .CHG(chg0));
    cell_sync_nffs #(.WIDTH(1), .STAGES(3), .RST_VAL(1'b1), .FILT_LEN(4)) u1 (
        .CK(CK), .RST(rst1), .D(d1), .Q(q1), .RISE(rise1), .FALL(fall1), .CHG(chg1));
    cell_sync_nffs #(.WIDTH(8), .STAGES(2), .RST_VAL(8'hA5), .FILT_LEN(0)) u2 (
        .CK(CK), .RST(rst2), .D(d2), .Q(q2), .RISE(rise2), .FALL(fall2), .CHG(chg2));
    cell_sync_nffs #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b0), .FILT_LEN(255)) u3 (
        .CK(CK), .RST(rst3), .D(d3), .Q(q3), .RISE(rise3), .FALL(fall3), .CHG(chg3));

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  q;
        logic [7:0]  rise;
        logic [7:0]  fall;
    } ev_t;

    ev_t sb0[$];
    ev_t sb1[$];
    ev_t sb2[$];
    ev_t sb3[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic expect_ev(input int id, input int unsigned at,
                             input logic [7:0] q, input logic [7:0] r, input logic [7:0] f);
        ev_t e;
        e.cyc  = at;
        e.q    = q;
        e.rise = r;
        e.fall = f;
        case (id)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            2:       sb2.push_back(e);
            default: sb3.push_back(e);
        endcase
    endtask

    task automatic mon(input int id, input logic chg,
                       input logic [7:0] q, input logic [7:0] r, input logic [7:0] f);
        ev_t  e;
        logic have;
        if (!chg) return;
        vectors++;
        have = 1'b1;
        e    = '0;
        case (id)
            0:       if (sb0.size() > 0) e = sb0.pop_front(); else have = 1'b0;
            1:       if (sb1.size() > 0) e = sb1.pop_front(); else have = 1'b0;
            2:       if (sb2.size() > 0) e = sb2.pop_front(); else have = 1'b0;
            default: if (sb3.size() > 0) e = sb3.pop_front(); else have = 1'b0;
        endcase
        if (!have) begin
            miscompares++;
            $display("FAIL edge_dut%0d: got edge at cyc=%0d q=%h rise=%h fall=%h, expected no edge",
                     id, cyc, q, r, f);
        end else if (e.cyc != cyc || e.q != q || e.rise != r || e.fall != f) begin
            miscompares++;
            $display("FAIL edge_dut%0d: got cyc=%0d q=%h rise=%h fall=%h, expected cyc=%0d q=%h rise=%h fall=%h",
                     id, cyc, q, r, f, e.cyc, e.q, e.rise, e.fall);
        end
    endtask

    always @(negedge CK) begin
        mon(0, chg0, {7'b0, q0}, {7'b0, rise0}, {7'b0, fall0});
        mon(1, chg1, {7'b0, q1}, {7'b0, rise1}, {7'b0, fall1});
        mon(2, chg2, q2, rise2, fall2);
        mon(3, chg3, {7'b0, q3}, {7'b0, rise3}, {7'b0, fall3});
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CK);
    endtask

    initial begin
        int unsigned n;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        d0 = 1'b1; d1 = 1'b1; d2 = 8'hA5; d3 = 1'b0;
        step(3);
        chk("rst_q0", {7'b0, q0}, 8'h01);
        chk("rst_q1", {7'b0, q1}, 8'h01);
        chk("rst_q2", q2, 8'hA5);
        chk("rst_q3", {7'b0, q3}, 8'h00);
        chk("rst_rise2", rise2, 8'h00);
        chk("rst_fall2", fall2, 8'h00);
        chk("rst_chg", {4'b0, chg0, chg1, chg2, chg3}, 8'h00);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        step(1);
        chk("post_rel_chg", {4'b0, chg0, chg1, chg2, chg3}, 8'h00);
        step(3);

        // FILT_LEN=0: fall, rise, then a single-cycle pulse passes straight through
        n = cyc; d0 = 1'b0; expect_ev(0, n + 2, 8'h00, 8'h00, 8'h01);
        step(6);
        n = cyc; d0 = 1'b1; expect_ev(0, n + 2, 8'h01, 8'h01, 8'h00);
        step(6);
        n = cyc; d0 = 1'b0;
        expect_ev(0, n + 2, 8'h00, 8'h00, 8'h01);
        expect_ev(0, n + 3, 8'h01, 8'h01, 8'h00);
        step(1); d0 = 1'b1;
        step(6);
        chk("final_q0", {7'b0, q0}, 8'h01);

        // Multi-channel: all bits move together, then one bit, then a mixed set
        n = cyc; d2 = 8'h5A; expect_ev(2, n + 2, 8'h5A, 8'h5A, 8'hA5);
        step(5);
        n = cyc; d2 = 8'h5B; expect_ev(2, n + 2, 8'h5B, 8'h01, 8'h00);
        step(5);
        n = cyc; d2 = 8'hA4; expect_ev(2, n + 2, 8'hA4, 8'hA4, 8'h5B);
        step(5);
        chk("final_q2", q2, 8'hA4);

        // FILT_LEN=4, STAGES=3: latency 7, glitch rejection, exact-length pulse
        n = cyc; d1 = 1'b0; expect_ev(1, n + 7, 8'h00, 8'h00, 8'h01);
        step(12);
        n = cyc; d1 = 1'b1; expect_ev(1, n + 7, 8'h01, 8'h01, 8'h00);
        step(12);
        d1 = 1'b0; step(3); d1 = 1'b1;
        step(12);
        chk("glitch_q1", {7'b0, q1}, 8'h01);
        n = cyc; d1 = 1'b0; expect_ev(1, n + 7, 8'h00, 8'h00, 8'h01);
        step(12);
        n = cyc; d1 = 1'b1;
        expect_ev(1, n + 7, 8'h01, 8'h01, 8'h00);
        expect_ev(1, n + 11, 8'h00, 8'h00, 8'h01);
        step(4); d1 = 1'b0;
        step(14);

        // Reset while the filter count sits at 2, then release with D opposite RST_VAL
        n = cyc; d1 = 1'b1;
        step(5);
        rst1 = 1'b1; d1 = 1'b0;
        #1;
        chk("midrst_q1", {7'b0, q1}, 8'h01);
        chk("midrst_pulses1", {5'b0, rise1, fall1, chg1}, 8'h00);
        step(2);
        chk("inrst_q1", {7'b0, q1}, 8'h01);
        rst1 = 1'b0;
        n = cyc; expect_ev(1, n + 7, 8'h00, 8'h00, 8'h01);
        step(1);
        chk("rel_chg1", {7'b0, chg1}, 8'h00);
        step(12);

        // FILT_LEN=255: 254-cycle excursion is rejected, 255-cycle holds pass
        d3 = 1'b1; step(254); d3 = 1'b0;
        step(260);
        chk("l254_q3", {7'b0, q3}, 8'h00);
        n = cyc; d3 = 1'b1; expect_ev(3, n + 257, 8'h01, 8'h01, 8'h00);
        step(270);
        n = cyc; d3 = 1'b0;
        expect_ev(3, n + 257, 8'h00, 8'h00, 8'h01);
        expect_ev(3, n + 512, 8'h01, 8'h01, 8'h00);
        step(255); d3 = 1'b1;
        step(270);
        chk("final_q3", {7'b0, q3}, 8'h01);

        chk("sb0_drained", 8'(sb0.size()), 8'h00);
        chk("sb1_drained", 8'(sb1.size()), 8'h00);
        chk("sb2_drained", 8'(sb2.size()), 8'h00);
        chk("sb3_drained", 8'(sb3.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
